rounder_pipe: RTL and testbench

ROUNDER_PIPE -- requirements
Module: Rounder_pipe

---
 rtl/rounder_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_rounder_pipe.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rounder_pipe.sv
// rounder_pipe: two-stage round/denormalise/renormalise back end with valid/ready flow control.
// Defining ROUNDER_FLAG_ACC_EN adds a sticky accumulator of exception flags on Fflags_acc_o.
module rounder_pipe #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter int PARM_RM   = 3
) (
  input  logic                 Clk_i,
  input  logic                 Rst_n_i,
  input  logic                 In_valid_i,
  output logic                 In_ready_o,
  input  logic                 Sign_i,
  input  logic [PARM_EXP+1:0]  Exp_i,
  input  logic [PARM_MANT+2:0] Mant_i,
  input  logic                 Sticky_i,
  input  logic [1:0]           Special_i,
  input  logic                 Invalid_i,
  input  logic [PARM_RM-1:0]   Rm_i,
  input  logic [PARM_RM-1:0]   Frm_i,
  output logic                 Out_valid_o,
  input  logic                 Out_ready_i,
  output logic                 Sign_o,
  output logic [PARM_EXP-1:0]  Exp_o,
  output logic [PARM_MANT-1:0] Mant_o,
  output logic [4:0]           Fflags_o,
  output logic [4:0]           Fflags_acc_o,
  input  logic                 Flag_clr_i
);

  localparam int MW = PARM_MANT + 3;
  localparam int XW = PARM_EXP + 2;
  localparam int SW = $clog2(MW + 1);

  localparam logic [1:0] SP_FIN  = 2'b00;
  localparam logic [1:0] SP_ZERO = 2'b01;
  localparam logic [1:0] SP_INF  = 2'b10;
  localparam logic [1:0] SP_NAN  = 2'b11;

  localparam logic [PARM_RM-1:0] RM_RNE = PARM_RM'(0);
  localparam logic [PARM_RM-1:0] RM_RTZ = PARM_RM'(1);
  localparam logic [PARM_RM-1:0] RM_RDN = PARM_RM'(2);
  localparam logic [PARM_RM-1:0] RM_RUP = PARM_RM'(3);
  localparam logic [PARM_RM-1:0] RM_RMM = PARM_RM'(4);
  localparam logic [PARM_RM-1:0] RM_DYN = PARM_RM'(7);

  localparam logic [PARM_EXP-1:0]  EXP_ONES = {PARM_EXP{1'b1}};
  localparam logic [PARM_EXP-1:0]  EXP_MAXF = {{(PARM_EXP-1){1'b1}}, 1'b0};
  localparam logic [PARM_MANT-1:0] NAN_MANT = {1'b1, {(PARM_MANT-1){1'b0}}};

  logic s1_free, s2_free, out_hs;

  // stage 1 combinational
  logic [PARM_RM-1:0] mode_eff;
  logic               mode_bad, tiny, lost, sticky_dn, inexact, up;
  logic [XW:0]        shamt_full;
  logic [SW-1:0]      shamt;
  logic [MW-1:0]      m_dn;
  logic [1:0]         kind;

  // stage 1 registers
  logic                 v1, sign1, up1, inexact1, tiny1;
  logic [1:0]           kind1;
  logic [PARM_EXP:0]    e1;
  logic [PARM_MANT:0]   hm1;
  logic [PARM_RM-1:0]   mode1;

  // stage 2 combinational
  logic [PARM_MANT+1:0] sum;
  logic [PARM_EXP+1:0]  e_rnd;
  logic [PARM_MANT-1:0] m_rnd;
  logic                 ovf, to_inf;
  logic                 sign_n;
  logic [PARM_EXP-1:0]  exp_n;
  logic [PARM_MANT-1:0] mant_n;
  logic [4:0]           flags_n;

  logic v2;

  assign s2_free     = ~v2 | Out_ready_i;
  assign s1_free     = ~v1 | s2_free;
  assign In_ready_o  = s1_free;
  assign Out_valid_o = v2;
  assign out_hs      = v2 & Out_ready_i;

  always_comb begin
    mode_eff = (Rm_i == RM_DYN) ? Frm_i : Rm_i;
    case (mode_eff)
      RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM: mode_bad = 1'b0;
      default:                                mode_bad = 1'b1;
    endcase
    tiny       = Exp_i[XW-1] | (Exp_i == '0);
    shamt_full = (XW+1)'(1) - {Exp_i[XW-1], Exp_i};
    if (!tiny)                            shamt = '0;
    else if (shamt_full >= (XW+1)'(MW))  shamt = SW'(MW);
    else                                  shamt = shamt_full[SW-1:0];
    m_dn      = Mant_i >> shamt;
    lost      = |(Mant_i & ~({MW{1'b1}} << shamt));
    sticky_dn = Sticky_i | lost;
    inexact   = m_dn[1] | m_dn[0] | sticky_dn;
    // m_dn[2] is the kept LSB, m_dn[1] guard, m_dn[0] round
    case (mode_eff)
      RM_RNE:  up = m_dn[1] & (m_dn[0] | sticky_dn | m_dn[2]);
      RM_RDN:  up = inexact & Sign_i;
      RM_RUP:  up = inexact & ~Sign_i;
      RM_RMM:  up = m_dn[1];
      default: up = 1'b0;
    endcase
    if (Special_i == SP_NAN || Invalid_i || mode_bad) kind = SP_NAN;
    else                                              kind = Special_i;
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      v1       <= 1'b0;
      sign1    <= 1'b0;
      up1      <= 1'b0;
      inexact1 <= 1'b0;
      tiny1    <= 1'b0;
      kind1    <= SP_FIN;
      e1       <= '0;
      hm1      <= '0;
      mode1    <= '0;
    end else if (s1_free) begin
      v1 <= In_valid_i;
      if (In_valid_i) begin
        sign1    <= Sign_i;
        up1      <= up;
        inexact1 <= inexact;
        tiny1    <= tiny;
        kind1    <= kind;
        e1       <= tiny ? '0 : Exp_i[PARM_EXP:0];
        hm1      <= m_dn[MW-1:2];
        mode1    <= mode_eff;
      end
    end
  end

  always_comb begin
    sum = {1'b0, hm1} + {{(PARM_MANT+1){1'b0}}, up1};
    // a subnormal that carries into the hidden bit becomes the minimum normal
    if (tiny1) e_rnd = {{(PARM_EXP+1){1'b0}}, sum[PARM_MANT]};
    else       e_rnd = {1'b0, e1} + {{(PARM_EXP+1){1'b0}}, sum[PARM_MANT+1]};
    m_rnd = sum[PARM_MANT+1] ? sum[PARM_MANT:1] : sum[PARM_MANT-1:0];
    ovf   = e_rnd >= {2'b00, EXP_ONES};
    case (mode1)
      RM_RNE, RM_RMM: to_inf = 1'b1;
      RM_RDN:         to_inf = sign1;
      RM_RUP:         to_inf = ~sign1;
      default:        to_inf = 1'b0;
    endcase
    sign_n  = sign1;
    exp_n   = '0;
    mant_n  = '0;
    flags_n = 5'b00000;
    case (kind1)
      SP_NAN: begin
        sign_n  = 1'b0;
        exp_n   = EXP_ONES;
        mant_n  = NAN_MANT;
        flags_n = 5'b10000;
      end
      SP_INF:  exp_n = EXP_ONES;
      SP_ZERO: exp_n = '0;
      default: begin
        if (ovf) begin
          exp_n   = to_inf ? EXP_ONES : EXP_MAXF;
          mant_n  = to_inf ? '0 : {PARM_MANT{1'b1}};
          flags_n = 5'b00101;
        end else begin
          exp_n   = e_rnd[PARM_EXP-1:0];
          mant_n  = m_rnd;
          flags_n = {3'b000, tiny1 & inexact1, inexact1};
        end
      end
    endcase
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      v2       <= 1'b0;
      Sign_o   <= 1'b0;
      Exp_o    <= '0;
      Mant_o   <= '0;
      Fflags_o <= '0;
    end else if (s2_free) begin
      v2 <= v1;
      if (v1) begin
        Sign_o   <= sign_n;
        Exp_o    <= exp_n;
        Mant_o   <= mant_n;
        Fflags_o <= flags_n;
      end
    end
  end

`ifdef ROUNDER_FLAG_ACC_EN
  // clear takes effect before the OR, so clear plus handshake keeps that handshake's flags
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i)                  Fflags_acc_o <= '0;
    else if (Flag_clr_i || out_hs) Fflags_acc_o <= (Flag_clr_i ? 5'd0 : Fflags_acc_o) |
                                                   (out_hs ? Fflags_o : 5'd0);
  end
`else
  logic unused_acc_inputs;
  assign unused_acc_inputs = Flag_clr_i | out_hs;
  assign Fflags_acc_o      = '0;
`endif

endmodule

// File: tb/tb_rounder_pipe.sv
// Scoreboard bench for rounder_pipe: a reference model fills the expected queue on input
// handshakes, output handshakes pop and compare.
module tb_rounder_pipe;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [25:0] mant;
    logic        sticky;
    logic [1:0]  special;
    logic        inv;
    logic [2:0]  rm;
    logic [2:0]  frm;
  } op_t;

`ifdef ROUNDER_FLAG_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic        Clk_i, Rst_n_i, In_valid_i, In_ready_o, Sign_i, Sticky_i, Invalid_i;
  logic [9:0]  Exp_i;
  logic [25:0] Mant_i;
  logic [1:0]  Special_i;
  logic [2:0]  Rm_i, Frm_i;
  logic        Out_valid_o, Out_ready_i, Sign_o, Flag_clr_i;
  logic [7:0]  Exp_o;
  logic [22:0] Mant_o;
  logic [4:0]  Fflags_o, Fflags_acc_o;

  rounder_pipe dut (
    .Clk_i(Clk_i), .Rst_n_i(Rst_n_i), .In_valid_i(In_valid_i), .In_ready_o(In_ready_o),
    .Sign_i(Sign_i), .Exp_i(Exp_i), .Mant_i(Mant_i), .Sticky_i(Sticky_i),
    .Special_i(Special_i), .Invalid_i(Invalid_i), .Rm_i(Rm_i), .Frm_i(Frm_i),
    .Out_valid_o(Out_valid_o), .Out_ready_i(Out_ready_i), .Sign_o(Sign_o), .Exp_o(Exp_o),
    .Mant_o(Mant_o), .Fflags_o(Fflags_o), .Fflags_acc_o(Fflags_acc_o), .Flag_clr_i(Flag_clr_i)
  );

  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];
  op_t         send_q[$];
  logic [4:0]  acc_model = 5'd0;
  int          ready_mode = 1;
  bit          gap_en = 1'b0;
  bit          clr_req = 1'b0;
  bit          prev_stall = 1'b0;
  int          accepted = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic op_t mk(input logic s, input int e, input logic [25:0] m, input logic st,
                             input logic [1:0] sp, input logic inv, input logic [2:0] rm,
                             input logic [2:0] frm);
    op_t o;
    o.sign = s; o.exp = 10'(e); o.mant = m; o.sticky = st;
    o.special = sp; o.inv = inv; o.rm = rm; o.frm = frm;
    return o;
  endfunction

  // reference: work on the integer significand, round, then renormalise
  function automatic logic [36:0] model(input op_t o);
    int ex, s, mode;
    longint q, t;
    bit st, g, rest, inx, up, tiny, inf_sel;
    mode = (o.rm == 3'd7) ? int'(o.frm) : int'(o.rm);
    if (o.special == 2'b11 || o.inv || mode > 4) return {1'b0, 8'hFF, 23'h400000, 5'b10000};
    if (o.special == 2'b10) return {o.sign, 8'hFF, 23'h0, 5'b0};
    if (o.special == 2'b01) return {o.sign, 8'h00, 23'h0, 5'b0};
    ex   = int'($signed(o.exp));
    q    = longint'(o.mant);
    st   = o.sticky;
    tiny = (ex <= 0);
    if (tiny) begin
      s = 1 - ex;
      if (s > 26) s = 26;
      if ((q & ((64'd1 << s) - 1)) != 0) st = 1'b1;
      q  = q >> s;
      ex = 0;
    end
    t    = q >> 2;
    g    = q[1];
    rest = q[0] | st;
    inx  = g | rest;
    case (mode)
      0:       up = g & (rest | t[0]);
      2:       up = inx & o.sign;
      3:       up = inx & ~o.sign;
      4:       up = g;
      default: up = 1'b0;
    endcase
    t = t + longint'(up);
    if (ex == 0) begin
      if (t >= (64'd1 << 23)) ex = 1;
    end else if (t >= (64'd1 << 24)) begin
      ex = ex + 1;
      t  = t >> 1;
    end
    if (ex >= 255) begin
      inf_sel = (mode == 0) || (mode == 4) || (mode == 2 && o.sign) || (mode == 3 && !o.sign);
      if (inf_sel) return {o.sign, 8'hFF, 23'h0, 5'b00101};
      else         return {o.sign, 8'hFE, 23'h7FFFFF, 5'b00101};
    end
    return {o.sign, 8'(ex), 23'(t), 3'b000, tiny & inx, inx};
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int r, n;
    logic [2:0] rms [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd7, 3'd5};
    o.sign = 1'($urandom_range(0, 1));
    r = int'($urandom_range(0, 9));
    if (r < 6)       o.exp = 10'($urandom_range(1, 254));
    else if (r < 8) begin n = int'($urandom_range(0, 30));   o.exp = 10'(-n); end
    else if (r == 8) o.exp = 10'($urandom_range(250, 300));
    else begin n = int'($urandom_range(31, 500)); o.exp = 10'(-n); end
    o.mant    = ($urandom_range(0, 7) == 0) ? 26'h3FFFFFF : {1'b1, 25'($urandom)};
    o.sticky  = 1'($urandom_range(0, 1));
    o.special = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    o.inv     = ($urandom_range(0, 19) == 0);
    o.rm      = rms[$urandom_range(0, 7)];
    o.frm     = 3'($urandom_range(0, 7));
    return o;
  endfunction

  task automatic drive(input op_t o);
    Sign_i = o.sign; Exp_i = o.exp; Mant_i = o.mant; Sticky_i = o.sticky;
    Special_i = o.special; Invalid_i = o.inv; Rm_i = o.rm; Frm_i = o.frm;
  endtask

  // entered just after a falling edge; drives, samples, then waits for the next falling edge
  task automatic tick();
    logic [36:0] e;
    logic [4:0]  e_flags;
    logic        hs_out;
    op_t         done;
    if (send_q.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
      drive(send_q[0]);
      In_valid_i = 1'b1;
    end else begin
      In_valid_i = 1'b0;
    end
    case (ready_mode)
      0:       Out_ready_i = 1'b0;
      1:       Out_ready_i = 1'b1;
      default: Out_ready_i = ($urandom_range(0, 3) != 0);
    endcase
    Flag_clr_i = clr_req;
    #1;
    if (prev_stall) check("hold_valid", 64'(Out_valid_o), 64'd1);
    check("acc", 64'(Fflags_acc_o), ACC_EN ? 64'(acc_model) : 64'd0);
    hs_out  = Out_valid_o & Out_ready_i;
    e_flags = 5'd0;
    if (hs_out) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", 64'(Out_valid_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out", 64'({Sign_o, Exp_o, Mant_o, Fflags_o}), 64'(e));
        e_flags = e[4:0];
      end
    end
    if (clr_req) acc_model = 5'd0;
    if (hs_out)  acc_model = acc_model | e_flags;
    prev_stall = Out_valid_o & ~Out_ready_i;
    if (In_valid_i && In_ready_o) begin
      exp_q.push_back(model(send_q[0]));
      done = send_q.pop_front();
      accepted++;
    end
    clr_req = 1'b0;
    @(negedge Clk_i);
  endtask

  task automatic drain();
    int n = 0;
    while ((send_q.size() != 0 || exp_q.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) check("drain_timeout", 64'(exp_q.size() + send_q.size()), 64'd0);
  endtask

  task automatic do_reset_checks(input string tag);
    check({tag, "_out_valid"}, 64'(Out_valid_o), 64'd0);
    check({tag, "_fflags"}, 64'(Fflags_o), 64'd0);
    check({tag, "_acc"}, 64'(Fflags_acc_o), 64'd0);
    check({tag, "_fields"}, 64'({Sign_o, Exp_o, Mant_o}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n_i = 1'b0; In_valid_i = 1'b0; Out_ready_i = 1'b0; Flag_clr_i = 1'b0;
    drive(mk(0, 0, 26'h0, 0, 2'b00, 0, 3'd0, 3'd0));
    #12;
    do_reset_checks("rst");
    @(negedge Clk_i);
    Rst_n_i = 1'b1;
    #1;
    check("rel_in_ready", 64'(In_ready_o), 64'd1);
    check("rel_out_valid", 64'(Out_valid_o), 64'd0);

    // directed corner cases
    send_q.push_back(mk(0, 127, {1'b1, 23'h000001, 1'b1, 1'b0}, 0, 2'b00, 0, 3'd0, 3'd0));
    send_q.push_back(mk(0, 254, 26'h3FFFFFF, 0, 2'b00, 0, 3'd0, 3'd0));
    send_q.push_back(mk(0, 254, 26'h3FFFFFF, 0, 2'b00, 0, 3'd1, 3'd0));
    send_q.push_back(mk(0, -30, 26'h2000000, 0, 2'b00, 0, 3'd3, 3'd0));
    send_q.push_back(mk(0, 0, 26'h2000000, 0, 2'b00, 0, 3'd0, 3'd0));
    send_q.push_back(mk(0, 0, {1'b1, 23'h7FFFFF, 1'b1, 1'b1}, 0, 2'b00, 0, 3'd0, 3'd0));
    send_q.push_back(mk(1, 100, 26'h1234567, 0, 2'b11, 0, 3'd0, 3'd0));
    send_q.push_back(mk(1, 100, 26'h2000000, 0, 2'b00, 1, 3'd0, 3'd0));
    send_q.push_back(mk(1, 33, 26'h2ABCDEF, 1, 2'b10, 0, 3'd0, 3'd0));
    send_q.push_back(mk(1, 33, 26'h2ABCDEF, 1, 2'b01, 0, 3'd1, 3'd0));
    send_q.push_back(mk(0, 254, 26'h3FFFFFF, 0, 2'b00, 0, 3'd7, 3'd1));
    send_q.push_back(mk(0, 100, 26'h2000000, 0, 2'b00, 0, 3'd5, 3'd0));
    send_q.push_back(mk(0, 100, 26'h2000000, 0, 2'b00, 0, 3'd7, 3'd7));
    send_q.push_back(mk(1, 254, 26'h3FFFFFF, 0, 2'b00, 0, 3'd2, 3'd0));
    send_q.push_back(mk(0, 254, 26'h3FFFFFF, 0, 2'b00, 0, 3'd2, 3'd0));
    send_q.push_back(mk(1, 254, 26'h3FFFFFF, 0, 2'b00, 0, 3'd3, 3'd0));
    send_q.push_back(mk(0, 100, {1'b1, 23'h0, 1'b1, 1'b0}, 0, 2'b00, 0, 3'd4, 3'd0));
    send_q.push_back(mk(0, 100, {1'b1, 23'h0, 1'b1, 1'b0}, 0, 2'b00, 0, 3'd0, 3'd0));
    ready_mode = 1;
    drain();

    // clear with no handshake, then clear coinciding with a handshake
    clr_req = 1'b1;
    tick();
    tick();
    send_q.push_back(mk(0, 127, {1'b1, 23'h000001, 1'b1, 1'b0}, 0, 2'b00, 0, 3'd0, 3'd0));
    send_q.push_back(mk(0, -5, 26'h2FFFFFF, 0, 2'b00, 0, 3'd0, 3'd0));
    tick();
    tick();
    clr_req = 1'b1;
    drain();

    // randomised traffic with gaps, random backpressure and an occasional clear
    gap_en = 1'b1;
    ready_mode = 2;
    for (int i = 0; i < 200; i++) send_q.push_back(rand_op());
    for (int i = 0; i < 150; i++) begin
      if (i % 37 == 20) clr_req = 1'b1;
      tick();
    end
    drain();
    gap_en = 1'b0;

    // four back-to-back ops against a stalled output
    ready_mode = 0;
    accepted = 0;
    for (int i = 0; i < 4; i++)
      send_q.push_back(mk(1'(i), 60 + i, {1'b1, 25'(i * 7919 + 3)}, 1'(i), 2'b00, 0, 3'(i), 3'd0));
    repeat (5) tick();
    check("bp_accepted", 64'(accepted), 64'd2);
    check("bp_in_ready", 64'(In_ready_o), 64'd0);
    ready_mode = 1;
    drain();
    check("bp_all_accepted", 64'(accepted), 64'd4);

    // reset with both stages occupied
    send_q.push_back(mk(0, 127, {1'b1, 23'h000001, 1'b1, 1'b0}, 0, 2'b00, 0, 3'd0, 3'd0));
    send_q.push_back(mk(0, 254, 26'h3FFFFFF, 0, 2'b00, 0, 3'd0, 3'd0));
    ready_mode = 0;
    repeat (3) tick();
    check("full_out_valid", 64'(Out_valid_o), 64'd1);
    check("full_in_ready", 64'(In_ready_o), 64'd0);
    #2;
    Rst_n_i = 1'b0;
    #1;
    do_reset_checks("rst_fly");
    exp_q.delete();
    send_q.delete();
    acc_model = 5'd0;
    prev_stall = 1'b0;
    @(negedge Clk_i);
    @(negedge Clk_i);
    Rst_n_i = 1'b1;
    #1;
    check("rel2_in_ready", 64'(In_ready_o), 64'd1);
    check("rel2_out_valid", 64'(Out_valid_o), 64'd0);
    ready_mode = 1;
    for (int i = 0; i < 6; i++) send_q.push_back(rand_op());
    drain();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
